mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Multi-channel external memory responder: the far end of the valid/ready memory protocol the GPU's memory controllers drive toward program and data memory.
- Each channel independently accepts one read or write request, waits a programmable latency, then returns ready (and read data) and holds it until the requester drops valid.
- Used as the program-memory and data-memory model in GPU-level benches. Also usable as a simple synthesizable on-chip RAM behind the controllers.
- A side load port preloads program and data contents before start.

Parameters:
- ADDR_BITS, 8, address width; depth is 2**ADDR_BITS rows.
- DATA_BITS, 8, word width (16 when used as program memory).
- NUM_CHANNELS, 4, number of independent request channels.
- LATENCY, 2, cycles from request acceptance to ready; legal range 1..15.
- WRITE_ENABLE, 1, 0 = read-only instance; write requests are never acknowledged.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- read_valid  in  NUM_CHANNELS  per-channel read request
- read_address  in  NUM_CHANNELS x ADDR_BITS  per-channel read address
- read_ready  out  NUM_CHANNELS  per-channel read acknowledge
- read_data  out  NUM_CHANNELS x DATA_BITS  per-channel read data, valid while read_ready=1
- write_valid  in  NUM_CHANNELS  per-channel write request
- write_address  in  NUM_CHANNELS x ADDR_BITS  per-channel write address
- write_data  in  NUM_CHANNELS x DATA_BITS  per-channel write data
- write_ready  out  NUM_CHANNELS  per-channel write acknowledge
- load_enable  in  1  preload strobe, single cycle per word
- load_address  in  ADDR_BITS  preload address
- load_data  in  DATA_BITS  preload data

Behaviour:
- Reset clears every per-channel FSM to IDLE, its latency counter to 0, and its captured request. On reset, read_ready=0, write_ready=0 and read_data=0 on all channels.
- The memory array is not cleared by reset; contents survive reset, including a reset asserted mid-transaction.
- Per-channel FSM states are IDLE, BUSY_RD, BUSY_WR, RESP_RD and RESP_WR.
- IDLE:
  - If read_valid is sampled 1 at edge t0: capture address, counter=LATENCY-1, go to BUSY_RD.
  - Otherwise, if write_valid=1 and WRITE_ENABLE=1: capture address and data, go to BUSY_WR.
  - If both are valid, the read wins; the write stays pending and is accepted once the channel returns to IDLE.
- BUSY_*:
  - The counter decrements each cycle.
  - On the edge where the counter is 0, move to RESP_*.
  - Result: ready rises exactly LATENCY cycles after t0. With LATENCY=1, ready is high in the cycle after the request is sampled.
- Abort: if the request's valid is sampled 0 while in BUSY_*, return to IDLE. No ready is raised and no write is committed.
- Read data: on entry to RESP_RD, mem[captured address] is registered into read_data and held stable throughout RESP_RD.
- Write commit: on entry to RESP_WR, mem[captured address] is written with the captured data.
- RESP_*:
  - Ready stays 1 while valid stays 1.
  - The first edge that samples valid=0 clears ready and returns the channel to IDLE.
  - A new request is sampled no earlier than the next edge, so there is at least one idle cycle between transactions.
- Same-edge collisions:
  - Load port versus channel write on the same address: load_enable wins.
  - Several channels committing to the same address: the highest channel index wins.
  - A read registering on the same edge as a write to the same address returns the old data (read-before-write).
- WRITE_ENABLE=0: write_valid is ignored, write_ready is tied to 0, and the array changes only through the load port.
- Addresses are used as-is. Every ADDR_BITS value is in range, so there is no wrap-around or out-of-range handling.

Test Plan:
- Preload mem[0x10]=0xA5. Channel 0 read_valid=1, addr 0x10 with LATENCY=2 → read_ready[0] rises 2 cycles after acceptance with read_data[0]=0xA5. Drop valid → ready falls on the next edge.
- Channel 1 write addr 0x20, data 0x3C, then channel 2 read addr 0x20 → write_ready[1] after 2 cycles; the read returns 0x3C.
- All 4 channels read addresses 0..3 (preloaded 0x11, 0x22, 0x33, 0x44) on the same cycle → all four readies rise on the same cycle with their own data.
- Channels 0 and 3 both write addr 0x40 (0x01 and 0x03) on the same cycle → a subsequent read of 0x40 returns 0x03.
- Drop read_valid during BUSY → no ready ever rises. Assert reset during RESP_WR after the commit → ready=0 immediately; mem still holds the written value.
- WRITE_ENABLE=0 with write_valid=1 held for 10 cycles → write_ready stays 0 and mem is unchanged. LATENCY=1 read → ready is high in the cycle after acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// Multi-channel valid/ready memory responder with programmable latency.
// Each channel serves one read or write at a time; a side port preloads the array.
module mem_responder #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned WRITE_ENABLE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready,
  input  logic                              load_enable,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_RD,
    BUSY_WR,
    RESP_RD,
    RESP_WR
  } state_e;

  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam int unsigned DEPTH  = 2 ** ADDR_BITS;

  state_e               state_q [NUM_CHANNELS];
  state_e               state_d [NUM_CHANNELS];
  logic [3:0]           cnt_q   [NUM_CHANNELS];
  logic [3:0]           cnt_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] commit;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
        rdata_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        addr_q[ch]  <= addr_d[ch];
        wdata_q[ch] <= wdata_d[ch];
        rdata_q[ch] <= rdata_d[ch];
      end
    end
  end

  always_comb begin
    commit = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      addr_d[ch]  = addr_q[ch];
      wdata_d[ch] = wdata_q[ch];
      rdata_d[ch] = rdata_q[ch];
      unique case (state_q[ch])
        IDLE: begin
          if (read_valid[ch]) begin
            addr_d[ch]  = read_address[ch*ADDR_BITS +: ADDR_BITS];
            cnt_d[ch]   = LAT_M1;
            state_d[ch] = BUSY_RD;
          end else if (WRITE_ENABLE != 0 && write_valid[ch]) begin
            addr_d[ch]  = write_address[ch*ADDR_BITS +: ADDR_BITS];
            wdata_d[ch] = write_data[ch*DATA_BITS +: DATA_BITS];
            cnt_d[ch]   = LAT_M1;
            state_d[ch] = BUSY_WR;
          end
        end
        BUSY_RD: begin
          if (!read_valid[ch]) begin
            state_d[ch] = IDLE;
          end else if (cnt_q[ch] == '0) begin
            rdata_d[ch] = mem_q[addr_q[ch]];
            state_d[ch] = RESP_RD;
          end else begin
            cnt_d[ch] = cnt_q[ch] - 4'd1;
          end
        end
        BUSY_WR: begin
          if (!write_valid[ch]) begin
            state_d[ch] = IDLE;
          end else if (cnt_q[ch] == '0) begin
            commit[ch]  = 1'b1;
            state_d[ch] = RESP_WR;
          end else begin
            cnt_d[ch] = cnt_q[ch] - 4'd1;
          end
        end
        RESP_RD: if (!read_valid[ch])  state_d[ch] = IDLE;
        RESP_WR: if (!write_valid[ch]) state_d[ch] = IDLE;
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  // Later non-blocking writes override earlier ones: higher channels beat lower, load beats all.
  always_ff @(posedge clk) begin
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (commit[ch]) mem_q[addr_q[ch]] <= wdata_q[ch];
    end
    if (load_enable) mem_q[load_address] <= load_data;
  end

  always_comb begin
    read_ready  = '0;
    write_ready = '0;
    read_data   = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      read_ready[ch]                           = (state_q[ch] == RESP_RD);
      write_ready[ch]                          = (state_q[ch] == RESP_WR);
      read_data[ch*DATA_BITS +: DATA_BITS]     = rdata_q[ch];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: main instance plus read-only and LATENCY=1 instances.
module tb_mem_responder;
  localparam int unsigned AB  = 8;
  localparam int unsigned DB  = 8;
  localparam int unsigned NC  = 4;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    rv = '0, wv = '0, rr, wr;
  logic [NC*AB-1:0] ra = '0, wa = '0;
  logic [NC*DB-1:0] wd = '0, rd;
  logic             le = 1'b0;
  logic [AB-1:0]    la = '0;
  logic [DB-1:0]    ld = '0;

  logic [NC-1:0]    ro_rv = '0, ro_wv = '0, ro_rr, ro_wr;
  logic [NC*AB-1:0] ro_ra = '0, ro_wa = '0;
  logic [NC*DB-1:0] ro_wd = '0, ro_rd;

  logic [NC-1:0]    l1_rv = '0, l1_wv = '0, l1_rr, l1_wr;
  logic [NC*AB-1:0] l1_ra = '0, l1_wa = '0;
  logic [NC*DB-1:0] l1_wd = '0, l1_rd;

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .read_valid(rv), .read_address(ra), .read_ready(rr), .read_data(rd),
    .write_valid(wv), .write_address(wa), .write_data(wd), .write_ready(wr),
    .load_enable(le), .load_address(la), .load_data(ld));

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT), .WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset(reset),
    .read_valid(ro_rv), .read_address(ro_ra), .read_ready(ro_rr), .read_data(ro_rd),
    .write_valid(ro_wv), .write_address(ro_wa), .write_data(ro_wd), .write_ready(ro_wr),
    .load_enable(le), .load_address(la), .load_data(ld));

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(1), .WRITE_ENABLE(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .read_valid(l1_rv), .read_address(l1_ra), .read_ready(l1_rr), .read_data(l1_rd),
    .write_valid(l1_wv), .write_address(l1_wa), .write_data(l1_wd), .write_ready(l1_wr),
    .load_enable(le), .load_address(la), .load_data(ld));

  typedef struct {
    int unsigned   ch;
    bit            is_wr;
    logic [DB-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DB-1:0] ref_mem [2**AB];
  logic [AB-1:0] b_addr [NC];
  logic [DB-1:0] b_data [NC];
  int unsigned   cyc = 0;
  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [NC-1:0] rr_prev = '0, wr_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic take(input int unsigned ch, input bit is_wr);
    int   idx;
    exp_t e;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].ch == ch) idx = i;
    end
    chk($sformatf("ready_expected ch%0d", ch), {31'd0, idx >= 0}, 32'd1);
    if (idx >= 0) begin
      e = sb[idx];
      sb.delete(idx);
      chk($sformatf("kind ch%0d", ch), {31'd0, is_wr}, {31'd0, e.is_wr});
      chk($sformatf("latency ch%0d", ch), cyc, e.cyc);
      if (!is_wr) chk($sformatf("rdata ch%0d", ch), {24'd0, rd[ch*DB +: DB]}, {24'd0, e.data});
    end
  endtask

  // Monitor: every rising ready on the main instance retires one scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      for (int unsigned ch = 0; ch < NC; ch++) begin
        if (rr[ch] && !rr_prev[ch]) take(ch, 1'b0);
        if (wr[ch] && !wr_prev[ch]) take(ch, 1'b1);
      end
    end
    rr_prev = rr;
    wr_prev = wr;
  end

  task automatic load(input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(negedge clk);
    le = 1'b1; la = a; ld = d;
    ref_mem[a] = d;
  endtask

  // Issue one transaction per selected channel in the same cycle, then complete the handshake.
  task automatic batch(input logic [NC-1:0] rm, input logic [NC-1:0] wm);
    logic [NC-1:0] m;
    int unsigned   n;
    m = rm | wm;
    @(negedge clk);
    for (int unsigned ch = 0; ch < NC; ch++) begin
      if (rm[ch]) begin
        rv[ch] = 1'b1;
        ra[ch*AB +: AB] = b_addr[ch];
        sb.push_back('{ch, 1'b0, ref_mem[b_addr[ch]], cyc + 1 + LAT});
      end else if (wm[ch]) begin
        wv[ch] = 1'b1;
        wa[ch*AB +: AB] = b_addr[ch];
        wd[ch*DB +: DB] = b_data[ch];
        sb.push_back('{ch, 1'b1, '0, cyc + 1 + LAT});
      end
    end
    for (int unsigned ch = 0; ch < NC; ch++) begin
      if (wm[ch] && !rm[ch]) ref_mem[b_addr[ch]] = b_data[ch];
    end
    n = 0;
    while ((((rr & rm) | (wr & wm)) != m) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("all_ready", {28'd0, (rr & rm) | (wr & wm)}, {28'd0, m});
    @(negedge clk);
    chk("ready_hold", {28'd0, (rr & rm) | (wr & wm)}, {28'd0, m});
    rv = rv & ~rm;
    wv = wv & ~wm;
    @(negedge clk);
    chk("ready_drop", {28'd0, (rr & rm) | (wr & wm)}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   n;
    logic [NC-1:0] rm, wm;

    #3 reset = 1'b1;
    #2;
    chk("rst_read_ready", {28'd0, rr}, 32'd0);
    chk("rst_write_ready", {28'd0, wr}, 32'd0);
    chk("rst_read_data", rd, 32'd0);
    chk("rst_ro_ready", {24'd0, ro_rr, ro_wr}, 32'd0);
    chk("rst_l1_ready", {24'd0, l1_rr, l1_wr}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 2**AB; a++) load(AB'(a), DB'($urandom));
    load(8'h10, 8'hA5);
    load(8'h00, 8'h11);
    load(8'h01, 8'h22);
    load(8'h02, 8'h33);
    load(8'h03, 8'h44);
    @(negedge clk);
    le = 1'b0;

    b_addr[0] = 8'h10; batch(4'b0001, 4'b0000);
    b_addr[1] = 8'h20; b_data[1] = 8'h3C; batch(4'b0000, 4'b0010);
    b_addr[2] = 8'h20; batch(4'b0100, 4'b0000);
    for (int unsigned ch = 0; ch < NC; ch++) b_addr[ch] = AB'(ch);
    batch(4'b1111, 4'b0000);
    b_addr[0] = 8'h40; b_data[0] = 8'h01;
    b_addr[3] = 8'h40; b_data[3] = 8'h03;
    batch(4'b0000, 4'b1001);
    b_addr[1] = 8'h40; batch(4'b0010, 4'b0000);
    b_addr[0] = 8'h50; b_addr[1] = 8'h50; b_data[1] = 8'h6E;
    batch(4'b0001, 4'b0010);
    b_addr[2] = 8'h50; batch(4'b0100, 4'b0000);

    // Load port and channel commit hit the same address on the same edge.
    @(negedge clk);
    wv[0] = 1'b1; wa[0 +: AB] = 8'h70; wd[0 +: DB] = 8'h55;
    sb.push_back('{0, 1'b1, '0, cyc + 1 + LAT});
    @(negedge clk);
    @(negedge clk);
    le = 1'b1; la = 8'h70; ld = 8'h99; ref_mem[8'h70] = 8'h99;
    @(negedge clk);
    le = 1'b0;
    chk("load_vs_write_ready", {31'd0, wr[0]}, 32'd1);
    wv[0] = 1'b0;
    @(negedge clk);
    b_addr[3] = 8'h70; batch(4'b1000, 4'b0000);

    // Abort during BUSY.
    @(negedge clk);
    rv[0] = 1'b1; ra[0 +: AB] = 8'h10;
    @(negedge clk);
    rv[0] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ready", {31'd0, rr[0]}, 32'd0);
    end

    // Reset while in RESP_WR after the commit.
    @(negedge clk);
    wv[0] = 1'b1; wa[0 +: AB] = 8'h60; wd[0 +: DB] = 8'h77;
    sb.push_back('{0, 1'b1, '0, cyc + 1 + LAT});
    ref_mem[8'h60] = 8'h77;
    n = 0;
    while (!wr[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wr_ready_before", {31'd0, wr[0]}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_wready", {31'd0, wr[0]}, 32'd0);
    chk("rst_async_rdata", rd, 32'd0);
    @(negedge clk);
    wv[0] = 1'b0;
    reset = 1'b0;
    b_addr[1] = 8'h60; batch(4'b0010, 4'b0000);

    for (int it = 0; it < 40; it++) begin
      rm = NC'($urandom);
      wm = NC'($urandom) & ~rm;
      if ((rm | wm) == '0) rm = 4'b0001;
      for (int unsigned ch = 0; ch < NC; ch++) begin
        b_addr[ch] = 8'h80 + AB'($urandom_range(0, 7));
        b_data[ch] = DB'($urandom);
      end
      batch(rm, wm);
    end

    // Read-only instance ignores writes.
    @(negedge clk);
    ro_wv = '1;
    for (int unsigned ch = 0; ch < NC; ch++) begin
      ro_wa[ch*AB +: AB] = 8'h10;
      ro_wd[ch*DB +: DB] = 8'hFF;
    end
    repeat (10) begin
      @(negedge clk);
      chk("ro_write_ready", {28'd0, ro_wr}, 32'd0);
    end
    ro_wv = '0;
    ro_rv[2] = 1'b1; ro_ra[2*AB +: AB] = 8'h10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ro_rr[2] && n < 40);
    chk("ro_read_latency", n, LAT + 1);
    chk("ro_read_data", {24'd0, ro_rd[2*DB +: DB]}, 32'h0000_00A5);
    ro_rv[2] = 1'b0;
    @(negedge clk);
    chk("ro_ready_drop", {31'd0, ro_rr[2]}, 32'd0);

    // LATENCY=1 instance.
    @(negedge clk);
    l1_rv[1] = 1'b1; l1_ra[1*AB +: AB] = 8'h10;
    @(negedge clk);
    chk("l1_busy", {31'd0, l1_rr[1]}, 32'd0);
    @(negedge clk);
    chk("l1_ready", {31'd0, l1_rr[1]}, 32'd1);
    chk("l1_data", {24'd0, l1_rd[1*DB +: DB]}, 32'h0000_00A5);
    l1_rv[1] = 1'b0;
    @(negedge clk);
    chk("l1_ready_drop", {31'd0, l1_rr[1]}, 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
